// File: rtl/oled_spi_pkg.sv
// Shared types for the OLED SPI slave receiver.
// FSM states, FIFO entry layout and frame byte limit.
package oled_spi_pkg;

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        ACTIVE
    } rx_state_t;

    typedef struct packed {
        logic       is_data;
        logic [7:0] data;
    } rx_entry_t;

    localparam int unsigned MAX_FRAME_BYTES = 15;

endpackage

// File: rtl/oled_spi_rx_fifo.sv
// First-word-fall-through FIFO of {is_data, byte} entries.
// Pointers carry one extra bit to tell full from empty.
module oled_spi_rx_fifo
    import oled_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  rx_entry_t din_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output rx_entry_t head_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    rx_entry_t   mem_q [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Advance read and write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/oled_spi_rx.sv
// SPI slave receiver: oversampled cs/sclk/mosi/d_c, MSB-first bytes into a FIFO.
// Define OLED_SPI_RX_STATS_EN to add cmd_count/data_count byte counters.
module oled_spi_rx
    import oled_spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        d_c,
    output logic [7:0]  rx_byte,
    output logic        rx_is_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_done,
    output logic [3:0]  frame_bytes,
    output logic        partial_err,
    output logic        overflow,
    input  logic        ovf_clr
`ifdef OLED_SPI_RX_STATS_EN
    ,
    output logic [15:0] cmd_count,
    output logic [15:0] data_count
`endif
);

    localparam int S = SYNC_STAGES;

    logic [S-1:0] cs_q;
    logic [S-1:0] sclk_q;
    logic [S-1:0] mosi_q;
    logic [S-1:0] dc_q;
    logic [S-1:0] prime_q;
    logic         sclk_dly_q;

    logic cs_s;
    logic mosi_s;
    logic dc_s;
    logic primed;
    logic sclk_rise;

    rx_state_t state_q;
    logic [6:0] shift_q;
    logic [2:0] bitcnt_q;
    logic [3:0] bytecnt_q;
    logic       tag_q;
    logic       push_q;
    rx_entry_t  push_entry_q;
    logic       frame_done_q;
    logic       partial_err_q;
    logic [3:0] frame_bytes_q;
    logic       overflow_q;
    logic       overflow_d;

    logic      fifo_full;
    logic      fifo_empty;
    rx_entry_t head;
    logic      pop;
    logic      accept;
    logic      drop;

    assign cs_s      = cs_q[S-1];
    assign mosi_s    = mosi_q[S-1];
    assign dc_s      = dc_q[S-1];
    assign primed    = prime_q[S-1];
    assign sclk_rise = sclk_q[S-1] & ~sclk_dly_q;

    // Pin synchronizers; prime_q marks when the chains hold real pin samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q       <= '1;
            sclk_q     <= '0;
            mosi_q     <= '0;
            dc_q       <= '0;
            prime_q    <= '0;
            sclk_dly_q <= 1'b0;
        end else begin
            cs_q       <= {cs_q[S-2:0], cs};
            sclk_q     <= {sclk_q[S-2:0], sclk};
            mosi_q     <= {mosi_q[S-2:0], mosi};
            dc_q       <= {dc_q[S-2:0], d_c};
            prime_q    <= {prime_q[S-2:0], 1'b1};
            sclk_dly_q <= sclk_q[S-1];
        end
    end

    // Frame FSM: byte assembly, FIFO push and end-of-frame reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESYNC;
            shift_q       <= '0;
            bitcnt_q      <= '0;
            bytecnt_q     <= '0;
            tag_q         <= 1'b0;
            push_q        <= 1'b0;
            push_entry_q  <= '0;
            frame_done_q  <= 1'b0;
            partial_err_q <= 1'b0;
            frame_bytes_q <= '0;
        end else begin
            push_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            partial_err_q <= 1'b0;
            case (state_q)
                RESYNC: begin
                    // The reset value of the cs chain is not a real deassertion.
                    if (primed && cs_s) state_q <= IDLE;
                end
                IDLE: begin
                    if (!cs_s) begin
                        state_q   <= ACTIVE;
                        bitcnt_q  <= '0;
                        bytecnt_q <= '0;
                        tag_q     <= dc_s;
                    end
                end
                ACTIVE: begin
                    if (cs_s) begin
                        state_q       <= IDLE;
                        frame_done_q  <= 1'b1;
                        frame_bytes_q <= bytecnt_q;
                        partial_err_q <= (bitcnt_q != 3'd0);
                    end else if (sclk_rise) begin
                        shift_q  <= {shift_q[5:0], mosi_s};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            push_q               <= 1'b1;
                            push_entry_q.is_data <= tag_q;
                            push_entry_q.data    <= {shift_q, mosi_s};
                            if (bytecnt_q != 4'(MAX_FRAME_BYTES))
                                bytecnt_q <= bytecnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= RESYNC;
            endcase
        end
    end

    oled_spi_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .din_i   (push_entry_q),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

    assign pop        = rx_valid & rx_ready;
    assign accept     = push_q & (~fifo_full | pop);
    assign drop       = push_q & fifo_full & ~pop;
    assign overflow_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

    // Sticky overflow flag; a drop outranks a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

`ifdef OLED_SPI_RX_STATS_EN
    logic [15:0] cmd_cnt_q;
    logic [15:0] data_cnt_q;

    // Count bytes actually accepted into the FIFO, split by tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_cnt_q  <= '0;
            data_cnt_q <= '0;
        end else if (accept) begin
            if (push_entry_q.is_data) data_cnt_q <= data_cnt_q + 16'd1;
            else                      cmd_cnt_q  <= cmd_cnt_q + 16'd1;
        end
    end

    assign cmd_count  = cmd_cnt_q;
    assign data_count = data_cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign rx_valid    = ~fifo_empty;
    assign rx_byte     = head.data;
    assign rx_is_data  = head.is_data;
    assign frame_done  = frame_done_q;
    assign frame_bytes = frame_bytes_q;
    assign partial_err = partial_err_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
SPI slave receiver for the OLED link: the display-side end of the 4-wire cs/sclk/mosi/d_c interface driven by our OLED SPI transmitter.
- Oversamples the SPI pins in the system clock domain and assembles MSB-first bytes.
- Tags each byte as command or data and buffers it in a small FIFO with a valid/ready output.
- Used as a display emulator in simulation and as a loopback checker on the FPGA.

Parameters:
FIFO_DEPTH, 8, number of {is_data, byte} entries buffered; power of two, at least 2.
SYNC_STAGES, 2, synchronizer flops on cs, sclk, mosi and d_c; at least 2.

Ports:
clk  input  1  system clock (100 MHz)
rst_n  input  1  asynchronous active-low reset
cs  input  1  chip select from master, active low
sclk  input  1  SPI clock from master; idle low, sample on rising edge
mosi  input  1  serial data, MSB first
d_c  input  1  0 = command, 1 = data; constant for the whole frame
rx_byte  output  8  head-of-FIFO byte
rx_is_data  output  1  head-of-FIFO d_c tag
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer pop; a pop occurs when rx_valid && rx_ready
frame_done  output  1  one-cycle pulse when cs deasserts after an active frame
frame_bytes  output  4  complete bytes in the last frame, saturating at 15; valid with frame_done, held until next frame_done
partial_err  output  1  one-cycle pulse, coincident with frame_done, when the frame ended mid-byte
overflow  output  1  sticky; set when a completed byte is dropped because the FIFO is full
ovf_clr  input  1  synchronous clear of overflow; set wins if both happen in the same cycle

Behaviour:
- Reset values:
  - rx_valid, frame_done, partial_err, overflow = 0; frame_bytes = 0.
  - rx_byte and rx_is_data = 0.
  - FIFO empty; bit count 0.
  - Synchronizer flops reset to cs = 1 and all other pins = 0.
- Synchronization and edge detection:
  - cs, sclk, mosi and d_c each pass through SYNC_STAGES flops.
  - An sclk rising edge is detected from the synchronized sclk and one extra delay flop.
  - Requirement: sclk high and low phases each last at least SYNC_STAGES+2 clk cycles.
  - Requirement: mosi is stable from SYNC_STAGES+1 cycles before to 1 cycle after each sclk rising edge.
  - The master's 20-cycle period with mosi updated mid-low-phase meets both requirements.
- FSM states:
  - RESYNC (reset state): wait for synchronized cs = 1, then go to IDLE. This prevents bit misalignment if reset releases mid-frame.
  - IDLE: on synchronized cs = 0, go to ACTIVE. On entry, clear the bit count and byte count, and latch synchronized d_c into the frame tag.
  - ACTIVE:
    - On each sclk rising edge: shift synchronized mosi into the LSB of the shift register (MSB first) and increment the 3-bit bit count.
    - When the 8th bit is shifted in: push {tag, byte}, increment the frame byte count (saturating at 15), wrap the bit count to 0.
    - On synchronized cs = 1: go to IDLE; pulse frame_done; load frame_bytes.
    - If the bit count is nonzero at that point, also pulse partial_err and discard the partial byte.
- sclk edges seen in IDLE or RESYNC are ignored.
- If cs rises in the same cycle as a detected sclk edge, the edge is ignored.
- Latency: rx_valid rises exactly SYNC_STAGES+2 clk cycles after the physical 8th sclk rising edge, when the FIFO was empty.
- FIFO behaviour:
  - First-word-fall-through; rx_byte and rx_is_data are valid whenever rx_valid = 1.
  - Push when full with no simultaneous pop: byte dropped, overflow set.
  - Push when full with a simultaneous pop: push accepted.
  - Pop when empty: ignored.
- A pointer-extra-bit scheme is used for full/empty detection; pointers wrap modulo FIFO_DEPTH.

Optional Feature:
OLED_SPI_RX_STATS_EN
- Defined:
  - Adds output ports cmd_count[15:0] and data_count[15:0].
  - Each counts bytes accepted into the FIFO with tag 0 and 1 respectively; dropped bytes are not counted.
  - Counters wrap at 16 bits and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package oled_spi_pkg:
  - rx_state_t enum {RESYNC, IDLE, ACTIVE}
  - packed struct rx_entry_t {is_data, byte[7:0]}
  - localparam MAX_FRAME_BYTES = 15
- Sub-module oled_spi_rx_fifo: synchronous FWFT FIFO of rx_entry_t, parameterized by FIFO_DEPTH, with push, pop, full, empty and head outputs.
- Synchronizers and the FSM live in oled_spi_rx.

Test Plan:
All stimulus uses sclk at clk/20 (10 low, 10 high cycles), with mosi changed 4 cycles after sclk falls.
1. cs low, d_c = 0, byte 0xAF, cs high -> one entry {0, 0xAF}; rx_valid 4 cycles after the 8th rising edge; frame_done with frame_bytes = 1; partial_err = 0.
2. d_c = 1 frame of 0x12, 0x34, 0x56 with rx_ready = 1 -> entries popped in order, all with is_data = 1; frame_bytes = 3.
3. rx_ready = 0, 10-byte frame 0x00..0x09 -> FIFO holds 0x00..0x07; overflow = 1; after draining, exactly 8 entries; ovf_clr pulse clears overflow.
4. cs deasserted after 5 bits of 0xFF -> partial_err and frame_done pulse in the same cycle; frame_bytes = 0; no entry pushed.
5. 16 sclk cycles with cs high -> no entries, no frame_done; next cs-low frame with 0x3C is received correctly.
6. rst_n pulsed after 3 bits of an active frame -> all outputs at reset values; remaining bits ignored (RESYNC); next full frame 0xA5 received exactly once; with OLED_SPI_RX_STATS_EN, cmd_count increments by 1.
